// File: rtl/pueo_trig_issuer_if.sv
// AXI4-Stream readout start-address channel from the trigger issuer to the URAM.
// 0-cycle (wires only); tvalid holds until tready is seen on a rising edge.
// The slave stalls the master by holding tready low.
interface pueo_trig_issuer_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pueo_trig_issuer.sv
// Trigger issuer: numbers trigger requests, sends URAM start address, then strobes the event buffer.
// Latency: request edge -> tvalid 2 cycles, handshake -> trig_valid 1 cycle; 3-cycle minimum issue spacing.
// Backpressure: tready low stalls in ADDR; full FIFO, run_stop or MAX_OUTSTANDING limit refuse or hold requests.

module pueo_trig_issuer_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_rdy_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_en    = wr_vld_i && !full_o;
        rd_en    = rd_rdy_i && !empty_o;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
        rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
        end
    end
endmodule

module pueo_trig_issuer #(
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [14:0] LOOKBACK        = 15'd50,
    parameter int          MAX_OUTSTANDING = 4,
    parameter logic [15:0] EVT_NO_INIT     = 16'h0000
) (
    input  logic                  memclk_i,
    input  logic                  memclk_rstn_i,
    input  logic                  run_rst_i,
    input  logic                  run_stop_i,
    input  logic                  trig_req_i,
    input  logic [14:0]           trig_req_time_i,
    input  logic                  evt_done_i,
    pueo_trig_issuer_if.master    m_axis,
    output logic [14:0]           trig_time_o,
    output logic [15:0]           event_no_o,
    output logic                  trig_valid_o,
    output logic                  busy_o,
    output logic [7:0]            drop_cnt_o,
    output logic                  overflow_o
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_TRIG} state_e;

    localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

    state_e      state_q, state_d;
    logic        fifo_empty;
    logic        fifo_full;
    logic [14:0] fifo_head;
    logic        fifo_wr;
    logic        drop;
    logic        pop;
    logic        hs;

    logic [14:0] time_q, time_d;
    logic [14:0] addr_q, addr_d;
    logic [15:0] evt_cnt_q, evt_cnt_d;
    logic [14:0] trig_time_q, trig_time_d;
    logic [15:0] event_no_q, event_no_d;
    logic [3:0]  out_cnt_q, out_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        overflow_q, overflow_d;
    logic        out_inc;
    logic        out_dec;

    // Writes are gated only by full inside the FIFO; a simultaneous pop never frees a slot early.
    assign fifo_wr = trig_req_i && !run_stop_i && !run_rst_i;
    assign drop    = trig_req_i && !run_rst_i && (run_stop_i || fifo_full);

    pueo_trig_issuer_fifo #(
        .WIDTH (15),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i    (memclk_i),
        .rst_n_i  (memclk_rstn_i),
        .clr_i    (run_rst_i),
        .wr_vld_i (fifo_wr),
        .wr_dat_i (trig_req_time_i),
        .rd_rdy_i (pop),
        .rd_dat_o (fifo_head),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
        if (!memclk_rstn_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        hs      = 1'b0;
        if (run_rst_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty && (out_cnt_q < MAX_OUT)) begin
                        state_d = S_ADDR;
                        pop     = 1'b1;
                    end
                end
                S_ADDR: begin
                    if (m_axis.tready) begin
                        state_d = S_TRIG;
                        hs      = 1'b1;
                    end
                end
                S_TRIG:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        m_axis.tvalid = (state_q == S_ADDR);
        m_axis.tdata  = {1'b0, addr_q};
        trig_valid_o  = (state_q == S_TRIG);
        trig_time_o   = trig_time_q;
        event_no_o    = event_no_q;
        busy_o        = !fifo_empty || (state_q != S_IDLE);
        drop_cnt_o    = drop_cnt_q;
        overflow_o    = overflow_q;
    end

    always_comb begin
        time_d      = time_q;
        addr_d      = addr_q;
        evt_cnt_d   = evt_cnt_q;
        trig_time_d = trig_time_q;
        event_no_d  = event_no_q;
        out_cnt_d   = out_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        overflow_d  = overflow_q | drop;
        out_inc     = (state_q == S_TRIG);
        out_dec     = evt_done_i && (out_cnt_q != 4'd0);

        if (pop) begin
            time_d    = fifo_head;
            addr_d    = fifo_head - LOOKBACK;
            evt_cnt_d = evt_cnt_q + 16'd1;
        end
        if (hs) begin
            trig_time_d = time_q;
            event_no_d  = evt_cnt_q;
        end
        if (out_inc && !out_dec) begin
            out_cnt_d = out_cnt_q + 4'd1;
        end else if (!out_inc && out_dec) begin
            out_cnt_d = out_cnt_q - 4'd1;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        if (run_rst_i) begin
            time_d      = '0;
            addr_d      = '0;
            evt_cnt_d   = EVT_NO_INIT;
            trig_time_d = '0;
            event_no_d  = '0;
            out_cnt_d   = '0;
            drop_cnt_d  = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge memclk_i or negedge memclk_rstn_i) begin
        if (!memclk_rstn_i) begin
            time_q      <= '0;
            addr_q      <= '0;
            evt_cnt_q   <= EVT_NO_INIT;
            trig_time_q <= '0;
            event_no_q  <= '0;
            out_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            time_q      <= time_d;
            addr_q      <= addr_d;
            evt_cnt_q   <= evt_cnt_d;
            trig_time_q <= trig_time_d;
            event_no_q  <= event_no_d;
            out_cnt_q   <= out_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
        end
    end
endmodule

// File: tb/tb_pueo_trig_issuer.sv
// Bench for pueo_trig_issuer: directed requests with hand-computed addresses and event numbers,
// checked by a scoreboard monitor sampling on the falling edge.
module tb_pueo_trig_issuer;
    logic        clk = 1'b0;
    logic        rstn;
    logic        run_rst, run_stop, trig_req, evt_done;
    logic [14:0] trig_time_in;
    logic [14:0] trig_time;
    logic [15:0] event_no;
    logic        trig_valid, busy, overflow;
    logic [7:0]  drop_cnt;

    logic        req_b;
    logic [14:0] time_b;
    logic [14:0] trig_time_b;
    logic [15:0] event_no_b;
    logic        trig_valid_b, busy_b, overflow_b;
    logic [7:0]  drop_cnt_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] exp_addr_q [$];
    logic [30:0] exp_trig_q [$];
    logic [15:0] exp_b_q    [$];

    pueo_trig_issuer_if ax ();
    pueo_trig_issuer_if bx ();

    always #5 clk = ~clk;

    pueo_trig_issuer dut (
        .memclk_i        (clk),
        .memclk_rstn_i   (rstn),
        .run_rst_i       (run_rst),
        .run_stop_i      (run_stop),
        .trig_req_i      (trig_req),
        .trig_req_time_i (trig_time_in),
        .evt_done_i      (evt_done),
        .m_axis          (ax.master),
        .trig_time_o     (trig_time),
        .event_no_o      (event_no),
        .trig_valid_o    (trig_valid),
        .busy_o          (busy),
        .drop_cnt_o      (drop_cnt),
        .overflow_o      (overflow)
    );

    // Second instance starts its counter just below the wrap point.
    pueo_trig_issuer #(.EVT_NO_INIT(16'hFFFE)) dut_w (
        .memclk_i        (clk),
        .memclk_rstn_i   (rstn),
        .run_rst_i       (1'b0),
        .run_stop_i      (1'b0),
        .trig_req_i      (req_b),
        .trig_req_time_i (time_b),
        .evt_done_i      (1'b0),
        .m_axis          (bx.master),
        .trig_time_o     (trig_time_b),
        .event_no_o      (event_no_b),
        .trig_valid_o    (trig_valid_b),
        .busy_o          (busy_b),
        .drop_cnt_o      (drop_cnt_b),
        .overflow_o      (overflow_b)
    );
    assign bx.tready = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [14:0] t, input logic [15:0] addr, input logic [15:0] evno);
        exp_addr_q.push_back(addr);
        exp_trig_q.push_back({t, evno});
        trig_req     = 1'b1;
        trig_time_in = t;
        tick(1);
        trig_req     = 1'b0;
    endtask

    task automatic send_nopush(input logic [14:0] t);
        trig_req     = 1'b1;
        trig_time_in = t;
        tick(1);
        trig_req     = 1'b0;
    endtask

    task automatic drain_to(input int n, input int budget);
        int i = 0;
        while ((exp_trig_q.size() > n) && (i < budget)) begin
            tick(1);
            i++;
        end
        check("drain_to", 32'(exp_trig_q.size()), 32'(n));
    endtask

    task automatic wait_trig(input int budget);
        int i = 0;
        while (!trig_valid && (i < budget)) begin
            tick(1);
            i++;
        end
        check("wait_trig", 32'(trig_valid), 32'd1);
    endtask

    // Scoreboard monitor for the main instance.
    logic        prev_hs = 1'b0, prev_wait = 1'b0, prev_tv = 1'b0;
    logic [15:0] prev_tdata = '0;
    logic [14:0] prev_tt = '0;
    logic [15:0] prev_en = '0;
    always @(negedge clk) begin
        logic [30:0] e;
        if (rstn) begin
            if (prev_wait) begin
                check("tvalid_hold", 32'(ax.tvalid), 32'd1);
                check("tdata_hold", 32'(ax.tdata), 32'(prev_tdata));
            end
            if (ax.tvalid && ax.tready && !run_rst) begin
                if (exp_addr_q.size() == 0) fail_now("unexpected_addr");
                else check("tdata", 32'(ax.tdata), 32'(exp_addr_q.pop_front()));
            end
            if (trig_valid) begin
                check("trig_after_hs", 32'(prev_hs), 32'd1);
                check("trig_one_cycle", 32'(prev_tv), 32'd0);
                if (exp_trig_q.size() == 0) fail_now("unexpected_trig");
                else begin
                    e = exp_trig_q.pop_front();
                    check("trig_time", 32'(trig_time), 32'(e[30:16]));
                    check("event_no", 32'(event_no), 32'(e[15:0]));
                end
            end else if (prev_tv) begin
                check("trig_time_hold", 32'(trig_time), 32'(prev_tt));
                check("event_no_hold", 32'(event_no), 32'(prev_en));
            end
            prev_hs    = ax.tvalid && ax.tready && !run_rst;
            prev_wait  = ax.tvalid && !ax.tready && !run_rst;
            prev_tdata = ax.tdata;
            prev_tv    = trig_valid;
            prev_tt    = trig_time;
            prev_en    = event_no;
        end
    end

    always @(negedge clk) begin
        if (rstn && trig_valid_b) begin
            if (exp_b_q.size() == 0) fail_now("unexpected_trig_wrap");
            else check("event_no_wrap", 32'(event_no_b), 32'(exp_b_q.pop_front()));
        end
    end

    initial begin
        #200000;
        fail_now("watchdog_timeout");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; run_rst = 1'b0; run_stop = 1'b0; trig_req = 1'b0; evt_done = 1'b0;
        trig_time_in = '0; ax.tready = 1'b0; req_b = 1'b0; time_b = '0;
        tick(3);
        check("rst_tvalid", 32'(ax.tvalid), 32'd0);
        check("rst_tdata", 32'(ax.tdata), 32'd0);
        check("rst_trig_valid", 32'(trig_valid), 32'd0);
        check("rst_trig_time", 32'(trig_time), 32'd0);
        check("rst_event_no", 32'(event_no), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rstn = 1'b1;
        tick(2);

        // Test 1: request driven just after edge R, sampled at R+1; tvalid from R+2, handshake at R+3.
        run_rst = 1'b1; tick(1); run_rst = 1'b0;
        ax.tready = 1'b1;
        send(15'd55, 16'h0005, 16'd1);
        check("lat_tvalid_low", 32'(ax.tvalid), 32'd0);
        check("lat_busy", 32'(busy), 32'd1);
        tick(1);
        check("lat_tvalid_high", 32'(ax.tvalid), 32'd1);
        check("lat_tdata", 32'(ax.tdata), 32'h0005);
        tick(1);
        check("lat_trig_valid", 32'(trig_valid), 32'd1);
        check("lat_event_no", 32'(event_no), 32'd1);
        check("lat_trig_time", 32'(trig_time), 32'd55);
        tick(1);
        check("lat_trig_low", 32'(trig_valid), 32'd0);
        check("lat_idle_busy", 32'(busy), 32'd0);

        // Test 2: second event.
        send(15'd90, 16'h0028, 16'd2);
        drain_to(0, 20);

        // Test 3: stalled handshake for 20+ cycles.
        ax.tready = 1'b0;
        send(15'd200, 16'h0096, 16'd3);
        tick(22);
        check("stall_tvalid", 32'(ax.tvalid), 32'd1);
        check("stall_no_trig", 32'(exp_trig_q.size()), 32'd1);
        ax.tready = 1'b1;
        drain_to(0, 10);

        // Test 4/5: six back-to-back requests, FIFO of 4, outstanding limit 4.
        run_rst = 1'b1; tick(1); run_rst = 1'b0;
        ax.tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send(15'(100 + k), 16'(50 + k), 16'(k + 1));
        end
        send_nopush(15'd105);
        tick(1);
        check("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        ax.tready = 1'b1;
        drain_to(1, 40);
        tick(10);
        check("limit_pending", 32'(exp_trig_q.size()), 32'd1);
        check("limit_tvalid", 32'(ax.tvalid), 32'd0);
        check("limit_busy", 32'(busy), 32'd1);
        send(15'd300, 16'h00FA, 16'd6);
        send(15'd10, 16'h7FD8, 16'd7);
        evt_done = 1'b1; tick(1); evt_done = 1'b0;
        wait_trig(10);
        // Done coincides with the issue strobe: the count must stay at 3.
        evt_done = 1'b1; tick(1); evt_done = 1'b0;
        drain_to(1, 20);
        tick(8);
        check("coincide_pending", 32'(exp_trig_q.size()), 32'd1);
        evt_done = 1'b1; tick(1); evt_done = 1'b0;
        drain_to(0, 20);

        // Test 6: run_rst while waiting in ADDR.
        run_rst = 1'b1; tick(1); run_rst = 1'b0;
        ax.tready = 1'b0;
        send_nopush(15'd500);
        tick(2);
        check("abort_tvalid_before", 32'(ax.tvalid), 32'd1);
        run_rst = 1'b1; tick(1); run_rst = 1'b0;
        check("abort_tvalid", 32'(ax.tvalid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_drop_clr", 32'(drop_cnt), 32'd0);
        check("abort_ovf_clr", 32'(overflow), 32'd0);
        ax.tready = 1'b1;
        send(15'd60, 16'h000A, 16'd1);
        drain_to(0, 20);

        // run_stop refuses requests and counts them; count saturates.
        run_stop = 1'b1;
        send_nopush(15'd70);
        send_nopush(15'd71);
        run_stop = 1'b0;
        tick(3);
        check("stop_drop_cnt", 32'(drop_cnt), 32'd2);
        check("stop_overflow", 32'(overflow), 32'd1);
        check("stop_busy", 32'(busy), 32'd0);
        run_stop = 1'b1; trig_req = 1'b1;
        tick(258);
        trig_req = 1'b0; run_stop = 1'b0;
        tick(1);
        check("drop_saturate", 32'(drop_cnt), 32'd255);

        // Event counter wrap on the preset instance.
        exp_b_q.push_back(16'hFFFF);
        req_b = 1'b1; time_b = 15'd20; tick(1); req_b = 1'b0;
        tick(6);
        exp_b_q.push_back(16'h0000);
        req_b = 1'b1; time_b = 15'd21; tick(1); req_b = 1'b0;
        tick(6);
        check("wrap_drained", 32'(exp_b_q.size()), 32'd0);
        check("final_addr_q", 32'(exp_addr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pueo_trig_issuer.md
Name: pueo_trig_issuer

Overview:
- Initiator side of the URAM readout-request interface.
- Accepts trigger requests carrying a 15-bit trigger time and numbers them with a per-run event counter.
- For each request, issues a readout start address to pueo_uram_v4 over AXI4-Stream (s_axis slave there). It then pulses trig_valid with time and number into uram_event_buffer_v3.
- Sits in the memclk domain between the trigger logic and the URAM/event-buffer pair.

Parameters:
- FIFO_DEPTH, 4: request FIFO entries; power of two, 2..16.
- LOOKBACK, 15'd50: subtracted from the trigger time to form the start address.
- MAX_OUTSTANDING, 4: maximum events issued but not yet completed; range 1..15.

Ports:
- memclk_i, input, 1: sole clock.
- memclk_rstn_i, input, 1: reset, asynchronous, active-low.
- run_rst_i, input, 1: synchronous run reset; flushes the FIFO and clears counters.
- run_stop_i, input, 1: while high, new trigger requests are refused.
- trig_req_i, input, 1: trigger request strobe, one cycle per request.
- trig_req_time_i, input, 15: trigger time for the request.
- evt_done_i, input, 1: one-cycle pulse from the event buffer when one event has been fully read out.
- m_axis_tdata, output, 16: readout start address.
- m_axis_tvalid, output, 1: address valid.
- m_axis_tready, input, 1: address accepted.
- trig_time_o, output, 15: trigger time to the event buffer.
- event_no_o, output, 16: event number to the event buffer.
- trig_valid_o, output, 1: one-cycle strobe to the event buffer.
- busy_o, output, 1: FIFO non-empty, or FSM not in IDLE.
- drop_cnt_o, output, 8: saturating count of refused or dropped requests.
- overflow_o, output, 1: sticky; set on any drop.

Behaviour:
- Async reset (memclk_rstn_i low): all outputs are 0, FIFO is empty, FSM is IDLE, event counter is 0, outstanding count is 0.
- run_rst_i has the same effect as reset, but is synchronous.
  - It overrides every other input in that cycle.
  - It aborts any handshake in progress: tvalid drops the following cycle.
- FIFO write: happens when trig_req_i is high, run_stop_i is low, and the FIFO is not full.
  - If trig_req_i is high while the FIFO is full, the request is dropped: drop_cnt_o increments (saturating at 255) and overflow_o is set.
  - A request refused because run_stop_i is high is also counted as a drop.
  - A write and a read in the same cycle while full is still a drop; there is no fall-through.
- FSM states:
  - IDLE: advance to ADDR when the FIFO is non-empty and the outstanding count is below MAX_OUTSTANDING.
    - On this transition, pop the FIFO head into a holding register.
    - Increment the event counter, so the first event of a run is number 1. The counter wraps 0xFFFF -> 0x0000.
  - ADDR: m_axis_tvalid = 1 and m_axis_tdata = {1'b0, (time - LOOKBACK) mod 2^15}.
    - tdata and tvalid are held stable until tready is seen high on a rising edge.
    - tvalid never deasserts without a handshake, except on run_rst_i.
    - On the handshake go to TRIG. tvalid is low in the following cycle.
  - TRIG: for one cycle, trig_valid_o = 1, trig_time_o = the held raw time (not offset), and event_no_o = the counter value.
    - Increment the outstanding count, then return to IDLE.
    - trig_time_o and event_no_o hold their last values after the strobe.
- Latency:
  - Request into an empty FIFO with tready held high: tvalid rises 2 cycles after the request edge, and the handshake completes on the next edge.
  - trig_valid_o follows 1 cycle after the handshake.
  - Minimum spacing between consecutive issues is 3 cycles.
- Outstanding count:
  - evt_done_i decrements it; evt_done_i is ignored when the count is 0.
  - Increment and decrement in the same cycle leave the count unchanged.
- Address subtraction wraps modulo 2^15, e.g. time 10 with LOOKBACK 50 gives 32728.
- busy_o = FIFO non-empty OR state != IDLE.

Test Plan:
1. Reset, then run_rst_i, then trig_req at time 55 with tready = 1 -> tdata = 0x0005, one tready handshake, trig_valid_o one cycle later with trig_time_o = 55 and event_no_o = 1.
2. Second request at time 90 -> tdata = 0x0028, event_no_o = 2, trig_valid high for exactly 1 cycle.
3. tready held low for 20 cycles -> tvalid and tdata stay stable throughout; trig_valid stays low until 1 cycle after tready goes high.
4. Six back-to-back requests with FIFO_DEPTH = 4 and tready low -> first request popped, next 4 buffered, 1 dropped. drop_cnt_o = 1 and overflow_o = 1. Releasing tready yields event_no 1 to 5 in order.
5. MAX_OUTSTANDING = 4 and no evt_done_i -> the 5th request waits in the FIFO. One evt_done_i pulse releases it; done and issue in the same cycle leave the count unchanged.
6. Edge cases:
   - time 10 -> tdata 0x7FD8.
   - Event counter preset path to 0xFFFF -> next event_no is 0x0000.
   - run_rst_i mid-ADDR -> tvalid low the next cycle, FIFO empty, next event_no = 1.
   - run_stop_i high -> requests are counted as drops.
